// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multi-cycle multiply/divide unit.
// The master side issues ops and reads HI/LO; the slave side is the unit itself.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, cancel, input busy, hi, lo);
    modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and a busy handshake.
// Optional MULDIV_ABORT_EN: cancel aborts an in-flight op and blocks a same-cycle start.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  mif
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;

    logic abort;
`ifdef MULDIV_ABORT_EN
    assign abort = mif.cancel;
`else
    logic unused_cancel;
    assign abort         = 1'b0;
    assign unused_cancel = mif.cancel;
`endif

    // Full-width products; the final value is produced in one step, only latency is modelled.
    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    assign prod_s = $signed({{WIDTH{mif.a[WIDTH-1]}}, mif.a}) *
                    $signed({{WIDTH{mif.b[WIDTH-1]}}, mif.b});
    assign prod_u = {{WIDTH{1'b0}}, mif.a} * {{WIDTH{1'b0}}, mif.b};

    // Signed divide on magnitudes; the most-negative / -1 case falls out as quotient=MIN, rem=0.
    logic             b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, den_s, den_u;
    logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    assign b_zero = (mif.b == '0);
    assign a_neg  = mif.a[WIDTH-1];
    assign b_neg  = mif.b[WIDTH-1];
    assign mag_a  = a_neg ? -mif.a : mif.a;
    assign mag_b  = b_neg ? -mif.b : mif.b;
    assign den_s  = b_zero ? WIDTH'(1) : mag_b;
    assign den_u  = b_zero ? WIDTH'(1) : mif.b;
    assign q_mag  = mag_a / den_s;
    assign r_mag  = mag_a % den_s;
    assign q_s    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s    = a_neg ? -r_mag : r_mag;
    assign q_u    = mif.a / den_u;
    assign r_u    = mif.a % den_u;

    logic [WIDTH-1:0] res_hi, res_lo;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (mif.op)
            3'd0: {res_hi, res_lo} = prod_s;
            3'd1: {res_hi, res_lo} = prod_u;
            3'd2: {res_hi, res_lo} = b_zero ? {mif.a, {WIDTH{1'b1}}} : {r_s, q_s};
            3'd3: {res_hi, res_lo} = b_zero ? {mif.a, {WIDTH{1'b1}}} : {r_u, q_u};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            IDLE: begin
                if (mif.start && !abort) begin
                    if (!mif.op[2]) begin
                        phi_d   = res_hi;
                        plo_d   = res_lo;
                        cnt_d   = mif.op[1] ? DIV_LOAD : MUL_LOAD;
                        state_d = RUN;
                    end else if (mif.op == OP_MTHI) begin
                        hi_d = mif.a;
                    end else if (mif.op == OP_MTLO) begin
                        lo_d = mif.a;
                    end
                end
            end
            RUN: begin
                // start is ignored here: nothing queues behind an in-flight op.
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    phi_d   = '0;
                    plo_d   = '0;
                end else if (cnt_q == '0) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign mif.busy = (state_q == RUN);
    assign mif.hi   = hi_q;
    assign mif.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan items plus randomized ops
// checked against a plain-arithmetic reference model of HI/LO and busy length.
module tb_muldiv_unit;
    localparam int W     = 32;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) mif ();

    muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [W-1:0] busy_exp);
        check({tag, " busy"}, W'(mif.busy), busy_exp);
        check({tag, " hi"}, mif.hi, exp_hi);
        check({tag, " lo"}, mif.lo, exp_lo);
    endtask

    // Reference: {HI, LO} from the architectural rules, using 64-bit integer arithmetic.
    function automatic logic [2*W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        longint          ps;
        longint unsigned pu;
        int              q, r;
        case (op)
            3'd0: begin ps = longint'(int'(a)) * longint'(int'(b)); return ps; end
            3'd1: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); return pu; end
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue a mult/div op, optionally inject an MTHI or a cancel at a given busy cycle (0 = none).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int mthi_at, input int cancel_at);
        logic [2*W-1:0] r;
        int             n;
        bit             cancelled;
        r         = ref_result(op, a, b);
        n         = (op < 3'd2) ? MUL_N : DIV_N;
        cancelled = 1'b0;
        mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
        tick();
        mif.start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            check_regs($sformatf("%s cyc%0d", tag, i), 32'd1);
            if (i == mthi_at) begin mif.start = 1'b1; mif.op = 3'd4; mif.a = 32'hDEAD_BEEF; end
            if (i == cancel_at) mif.cancel = 1'b1;
            tick();
            mif.start  = 1'b0;
            mif.cancel = 1'b0;
`ifdef MULDIV_ABORT_EN
            if (i == cancel_at) begin cancelled = 1'b1; break; end
`endif
        end
        if (!cancelled) {exp_hi, exp_lo} = r;
        check_regs({tag, " done"}, 32'd0);
    endtask

    task automatic mt_op(input string tag, input logic [2:0] op, input logic [W-1:0] a);
        mif.start = 1'b1; mif.op = op; mif.a = a;
        tick();
        mif.start = 1'b0;
        if (op == 3'd4) exp_hi = a;
        if (op == 3'd5) exp_lo = a;
        check_regs(tag, 32'd0);
    endtask

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        mif.start = 1'b0; mif.op = 3'd0; mif.a = '0; mif.b = '0; mif.cancel = 1'b0;
        tick();
        tick();
        check_regs("reset", 32'd0);
        rst_n = 1'b1;
        tick();
        check_regs("post-reset", 32'd0);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        check("mult hi const", mif.hi, 32'hFFFF_FFFF);
        check("mult lo const", mif.lo, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
        check("multu hi const", mif.hi, 32'h0000_0002);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div lo const", mif.lo, 32'hFFFF_FFFD);
        check("div hi const", mif.hi, 32'hFFFF_FFFF);
        run_op("divu", 3'd3, 32'd7, 32'd2, 0, 0);
        run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div ovf lo const", mif.lo, 32'h8000_0000);
        run_op("divu by0", 3'd3, 32'h1234, 32'd0, 0, 0);
        check("divu by0 hi const", mif.hi, 32'h1234);
        run_op("div by0", 3'd2, 32'hFFFF_FF00, 32'd0, 0, 0);

        mt_op("mthi", 3'd4, 32'hAAAA_0000);
        mt_op("mtlo", 3'd5, 32'h0000_5555);
        mt_op("nop6", 3'd6, 32'h1111_1111);
        mt_op("nop7", 3'd7, 32'h2222_2222);
        run_op("mult+mthi", 3'd0, 32'h0001_0003, 32'h0000_0007, 2, 0);

        // Reset during the 4th busy cycle of a divide.
        mif.start = 1'b1; mif.op = 3'd2; mif.a = 32'd100; mif.b = 32'd7;
        tick();
        mif.start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        check_regs("async reset", 32'd0);
        tick();
        rst_n = 1'b1;
        run_op("mult after reset", 3'd0, 32'd12, 32'hFFFF_FFFD, 0, 0);

        mt_op("mthi 1", 3'd4, 32'd1);
        mt_op("mtlo 2", 3'd5, 32'd2);
        run_op("mult cancel", 3'd0, 32'h0000_0100, 32'h0000_0100, 0, 3);
`ifdef MULDIV_ABORT_EN
        check("cancel hi kept", mif.hi, 32'd1);
        check("cancel lo kept", mif.lo, 32'd2);
        mif.start = 1'b1; mif.op = 3'd0; mif.a = 32'd5; mif.b = 32'd5; mif.cancel = 1'b1;
        tick();
        mif.start = 1'b0; mif.cancel = 1'b0;
        check_regs("cancel blocks start", 32'd0);
`endif

        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            if (rop < 3'd4) run_op($sformatf("rnd%0d op%0d", k, rop), rop, ra, rb, 0, 0);
            else mt_op($sformatf("rnd%0d op%0d", k, rop), rop, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
